scudsp_dma: RTL and testbench
=============================

Name: scudsp_dma

Overview:
- DMA engine of the SCU DSP; sits directly downstream of the DSP instruction decoder.
- Consumes the decoded DMA fields (start, direction, RAM/program-RAM selects) plus the sequencer-resolved count, address-increment mode and hold flag.
- Moves 32-bit words between the external D0 bus and DSP data RAM banks 0-3 or program RAM.
- Advances the CTx counter of the bank it uses, and writes back RA0/WA0 on completion.

Parameters:
- AW, 25, D0 word-address width (byte address = {addr, 2'b00}).
- PAW, 8, program RAM address width.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset; asynchronous, active-low.
- CE  in  1  clock enable; state advances only when 1.
- ST  in  1  start pulse (decoded DMA start).
- DIR  in  1  0: D0->RAM, 1: RAM->D0.
- RAMW  in  4  one-hot data RAM bank write select (DIR=0).
- PRGW  in  1  program RAM write select (DIR=0).
- RAMR  in  4  one-hot data RAM bank read select (DIR=1).
- CNT  in  8  word count; 0 means 256.
- ADDI  in  3  D0 address increment mode.
- HOLD  in  1  1: suppress RA0/WA0 write-back.
- RA0_IN  in  AW  D0 read start address.
- WA0_IN  in  AW  D0 write start address.
- RA0_OUT  out  AW  updated RA0.
- WA0_OUT  out  AW  updated WA0.
- RA0_UPD  out  1  one-CE pulse: load RA0_OUT.
- WA0_UPD  out  1  one-CE pulse: load WA0_OUT.
- A_ADDR  out  AW  D0 word address.
- A_DO  out  32  D0 write data.
- A_DI  in  32  D0 read data, valid with A_ACK.
- A_REQ  out  1  D0 request.
- A_WE  out  1  D0 write strobe, qualified by A_REQ.
- A_ACK  in  1  D0 acknowledge, single CLK pulse.
- RAM_WE  out  4  data RAM bank write strobes.
- RAM_RE  out  4  data RAM bank read strobes.
- RAM_WD  out  32  data RAM write data.
- RAM_RD  in  32  selected bank read data, valid one CE cycle after RAM_RE.
- CT_INC  out  4  CTx increment pulses.
- PRG_WE  out  1  program RAM write strobe.
- PRG_ADDR  out  PAW  program RAM address.
- PRG_WD  out  32  program RAM write data.
- BUSY  out  1  transfer in progress (T0 flag).
- DONE  out  1  one-CE pulse on completion.

Behaviour:
- Reset: all outputs 0, state IDLE, counters cleared.
- Reset mid-transfer: immediate abort to IDLE. No write-back. Partially written RAM contents are left as-is.
- Pulses: every strobe and pulse output is exactly one CE=1 cycle wide.
- A_ACK capture: latched into ack_pend on any CLK edge; consumed on the next CE=1 edge. Cleared by reset.
- Increment table, words, indexed by ADDI 0..7: 0, 1, 2, 4, 8, 16, 32, 64.
- Address arithmetic: addr = addr + inc, modulo 2^AW.
- Start (IDLE, CE, ST=1):
  - Latch all inputs; rem = CNT (0 -> 256).
  - addr = RA0_IN if DIR=0, else WA0_IN.
  - PRG_ADDR = 0; BUSY=1 from the next cycle.
- ST while BUSY: ignored.
- Target select: if RAMW and PRGW are both 0 (DIR=0) or RAMR=0 (DIR=1), the engine still runs the bus cycles but performs no RAM/PRG writes and no CT_INC pulses.
- DIR=0 flow: BUSRD -> RAMWR, repeated per word.
  - BUSRD: A_REQ=1, A_WE=0, A_ADDR=addr. Hold until ack_pend; then latch A_DI, addr += inc, go to RAMWR.
  - RAMWR, RAMW bank selected: RAM_WE[n]=1, CT_INC[n]=1, RAM_WD=data.
  - RAMWR, PRGW selected: PRG_WE=1, PRG_WD=data; PRG_ADDR increments after the write, modulo 2^PAW.
  - RAMWR exit: rem -= 1; rem=0 -> FIN, else BUSRD.
- DIR=1 flow: RAMRD -> RAMLAT -> BUSWR, repeated per word.
  - RAMRD: RAM_RE[n]=1, CT_INC[n]=1.
  - RAMLAT: latch RAM_RD.
  - BUSWR: A_REQ=1, A_WE=1, A_DO=latched data. Hold until ack_pend; then addr += inc, rem -= 1, go to FIN or RAMRD.
- A_REQ drop: deasserted in the cycle after ack consumption.
- FIN (one CE cycle):
  - DONE=1.
  - HOLD=0: DIR=0 pulses RA0_UPD, DIR=1 pulses WA0_UPD, with OUT = final addr.
  - Next state IDLE; BUSY falls at the same edge.
- Minimum latency with ACK in the first REQ cycle:
  - D0->RAM: 2 CE cycles/word.
  - RAM->D0: 3 CE cycles/word.
  - Plus 1 cycle FIN.
- ADDI=0: same address every word; write-back value equals the start address.

Test Plan:
- D0->RAM: DIR=0, RAMW=0001, CNT=4, ADDI=1, RA0_IN=0x100, immediate ACK, A_DI=0xA0..0xA3 -> RAM_WE[0] ×4 with data A0..A3; CT_INC[0] ×4; A_ADDR 0x100..0x103; RA0_OUT=0x104; RA0_UPD, DONE; BUSY high for 9 cycles.
- RAM->D0: DIR=1, RAMR=0100, CNT=2, ADDI=3, WA0_IN=0x200, RAM_RD=0x11,0x22 -> writes to 0x200 and 0x204 with A_DO 0x11, 0x22; CT_INC[2] ×2; WA0_OUT=0x208.
- Program load: DIR=0, PRGW=1, CNT=0 -> 256 PRG_WE at PRG_ADDR 0..255; HOLD=1 -> no RA0_UPD; DONE once.
- Wait/wrap: RA0_IN=0x1FFFFFF, ADDI=1, CNT=2, ACK delayed 5 cycles each -> A_REQ held; addresses 0x1FFFFFF then 0x0000000; RA0_OUT=0x0000001.
- Abort: RST_N low during word 2 of a 4-word transfer -> all outputs 0 immediately; no UPD/DONE. A fresh ST after reset runs normally.
- ST pulsed while BUSY and CE toggling 1/0 -> second ST ignored; per-word cycle counts scale with CE. A_ACK arriving during CE=0 is not lost.

Source files
------------

// File: rtl/scudsp_dma.sv
// ---------------------------------------------------------------------------
// scudsp_dma
//
// Purpose:
//   DMA engine of the SCU DSP. Takes the decoded DMA fields from the DSP
//   instruction decoder (start, direction, bank selects) together with the
//   sequencer-resolved word count, address increment mode and hold flag, and
//   moves 32-bit words between the external D0 bus and either the four DSP
//   data RAM banks or program RAM. The engine pulses the CTx increment of the
//   bank it touches. On completion it writes RA0 (reads from D0) or WA0
//   (writes to D0) back unless hold is set.
//
// Parameters:
//   AW  - D0 word-address width (byte address = {addr, 2'b00})
//   PAW - program RAM address width
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   ce                 clock enable; the FSM only advances when ce = 1
//   st                 start pulse, honoured only while idle
//   dir                0: D0 -> RAM, 1: RAM -> D0
//   ramw, prgw         one-hot data RAM bank / program RAM write selects
//   ramr               one-hot data RAM bank read select
//   cnt                word count, 0 encodes 256
//   addi               D0 address increment mode (0,1,2,4,...,64 words)
//   hold               suppress the RA0/WA0 write-back
//   ra0_in, wa0_in     D0 read / write start addresses
//   ra0_out, wa0_out   updated RA0 / WA0 values
//   ra0_upd, wa0_upd   one-CE load pulses for ra0_out / wa0_out
//   a_addr, a_do, a_di D0 word address, write data, read data
//   a_req, a_we, a_ack D0 request, write strobe, single-clk acknowledge
//   ram_we, ram_re     data RAM bank write / read strobes
//   ram_wd, ram_rd     data RAM write data / selected bank read data
//   ct_inc             CTx increment pulses, one per bank
//   prg_we, prg_addr,
//   prg_wd             program RAM write strobe, address and data
//   busy               transfer in progress (T0 flag)
//   done               one-CE pulse when a transfer completes
// ---------------------------------------------------------------------------
module scudsp_dma #(
  parameter int AW  = 25,
  parameter int PAW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           st,
  input  logic           dir,
  input  logic [3:0]     ramw,
  input  logic           prgw,
  input  logic [3:0]     ramr,
  input  logic [7:0]     cnt,
  input  logic [2:0]     addi,
  input  logic           hold,
  input  logic [AW-1:0]  ra0_in,
  input  logic [AW-1:0]  wa0_in,
  output logic [AW-1:0]  ra0_out,
  output logic [AW-1:0]  wa0_out,
  output logic           ra0_upd,
  output logic           wa0_upd,
  output logic [AW-1:0]  a_addr,
  output logic [31:0]    a_do,
  input  logic [31:0]    a_di,
  output logic           a_req,
  output logic           a_we,
  input  logic           a_ack,
  output logic [3:0]     ram_we,
  output logic [3:0]     ram_re,
  output logic [31:0]    ram_wd,
  input  logic [31:0]    ram_rd,
  output logic [3:0]     ct_inc,
  output logic           prg_we,
  output logic [PAW-1:0] prg_addr,
  output logic [31:0]    prg_wd,
  output logic           busy,
  output logic           done
);

  typedef enum logic [2:0] {
    IDLE,
    BUSRD,
    RAMWR,
    RAMRD,
    RAMLAT,
    BUSWR,
    FIN
  } state_t;

  state_t        state;

  // Transfer parameters captured at start so the decoder may move on.
  logic          dir_q;
  logic [3:0]    ramw_q;
  logic          prgw_q;
  logic [3:0]    ramr_q;
  logic [2:0]    addi_q;
  logic          hold_q;

  logic [8:0]    rem_q;
  logic [AW-1:0] addr_q;

  // An acknowledge may arrive while ce = 0; it and its data are parked here
  // until the next enabled edge so the handshake is never lost.
  logic          ack_pend;
  logic [31:0]   ack_data;

  logic [AW-1:0] inc;
  logic [AW-1:0] addr_nx;
  logic          ack_ok;
  logic [31:0]   bus_data;
  logic          last_word;

  // Increment table: mode 0 holds the address, mode k steps by 2^(k-1) words.
  always_comb begin
    inc = '0;
    if (addi_q != 3'd0) begin
      inc = AW'(1) << (addi_q - 3'd1);
    end
  end

  // The address wraps naturally at 2^AW. A live a_ack counts as well as a
  // parked one, which gives the minimum one-cycle bus phase when the slave
  // answers in the first request cycle.
  always_comb begin
    addr_nx   = addr_q + inc;
    ack_ok    = ack_pend | a_ack;
    bus_data  = ack_pend ? ack_data : a_di;
    last_word = (rem_q == 9'd1);
  end

  // Single state machine. Every output is registered and describes the state
  // being entered. Pulse outputs are cleared on every enabled edge, so each
  // one lasts exactly one ce = 1 cycle no matter how ce is gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dir_q    <= 1'b0;
      ramw_q   <= '0;
      prgw_q   <= 1'b0;
      ramr_q   <= '0;
      addi_q   <= '0;
      hold_q   <= 1'b0;
      rem_q    <= '0;
      addr_q   <= '0;
      ack_pend <= 1'b0;
      ack_data <= '0;
      ra0_out  <= '0;
      wa0_out  <= '0;
      ra0_upd  <= 1'b0;
      wa0_upd  <= 1'b0;
      a_addr   <= '0;
      a_do     <= '0;
      a_req    <= 1'b0;
      a_we     <= 1'b0;
      ram_we   <= '0;
      ram_re   <= '0;
      ram_wd   <= '0;
      ct_inc   <= '0;
      prg_we   <= 1'b0;
      prg_addr <= '0;
      prg_wd   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (a_ack) begin
        ack_data <= a_di;
      end
      if (ce) begin
        ack_pend <= 1'b0;
      end else if (a_ack) begin
        ack_pend <= 1'b1;
      end

      if (ce) begin
        ram_we  <= '0;
        ram_re  <= '0;
        ct_inc  <= '0;
        prg_we  <= 1'b0;
        done    <= 1'b0;
        ra0_upd <= 1'b0;
        wa0_upd <= 1'b0;

        unique case (state)
          IDLE: begin
            if (st) begin
              dir_q    <= dir;
              ramw_q   <= ramw;
              prgw_q   <= prgw;
              ramr_q   <= ramr;
              addi_q   <= addi;
              hold_q   <= hold;
              rem_q    <= (cnt == 8'd0) ? 9'd256 : {1'b0, cnt};
              prg_addr <= '0;
              busy     <= 1'b1;
              if (!dir) begin
                addr_q <= ra0_in;
                a_addr <= ra0_in;
                a_req  <= 1'b1;
                a_we   <= 1'b0;
                state  <= BUSRD;
              end else begin
                addr_q <= wa0_in;
                ram_re <= ramr;
                ct_inc <= ramr;
                state  <= RAMRD;
              end
            end
          end

          // With no bank or program RAM selected the bus cycles still run,
          // but the all-zero selects leave every RAM strobe low.
          BUSRD: begin
            if (ack_ok) begin
              a_req  <= 1'b0;
              addr_q <= addr_nx;
              ram_we <= ramw_q;
              ct_inc <= ramw_q;
              ram_wd <= bus_data;
              prg_we <= prgw_q;
              prg_wd <= bus_data;
              state  <= RAMWR;
            end
          end

          // The program RAM address moves only after the write it addressed.
          RAMWR: begin
            if (prgw_q) begin
              prg_addr <= prg_addr + 1'b1;
            end
            rem_q <= rem_q - 9'd1;
            if (last_word) begin
              done <= 1'b1;
              if (!hold_q) begin
                ra0_upd <= 1'b1;
                ra0_out <= addr_q;
              end
              state <= FIN;
            end else begin
              a_addr <= addr_q;
              a_req  <= 1'b1;
              a_we   <= 1'b0;
              state  <= BUSRD;
            end
          end

          RAMRD: begin
            state <= RAMLAT;
          end

          // Bank read data becomes valid one enabled cycle after the strobe.
          RAMLAT: begin
            a_do   <= ram_rd;
            a_addr <= addr_q;
            a_req  <= 1'b1;
            a_we   <= 1'b1;
            state  <= BUSWR;
          end

          BUSWR: begin
            if (ack_ok) begin
              a_req  <= 1'b0;
              a_we   <= 1'b0;
              addr_q <= addr_nx;
              rem_q  <= rem_q - 9'd1;
              if (last_word) begin
                done <= 1'b1;
                if (!hold_q) begin
                  wa0_upd <= 1'b1;
                  wa0_out <= addr_nx;
                end
                state <= FIN;
              end else begin
                ram_re <= ramr_q;
                ct_inc <= ramr_q;
                state  <= RAMRD;
              end
            end
          end

          FIN: begin
            busy  <= 1'b0;
            state <= IDLE;
          end

          default: begin
            busy  <= 1'b0;
            a_req <= 1'b0;
            a_we  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scudsp_dma.sv
// ---------------------------------------------------------------------------
// tb_scudsp_dma
//
// Scoreboard bench for scudsp_dma. Each directed transfer pushes its expected
// observable events (bus handshakes, RAM strobes, program RAM writes,
// completion) into a queue. A monitor pops and compares whenever the DUT
// presents one of those events. A small bus / RAM responder supplies read
// data with a programmable acknowledge delay, and a ce generator can toggle
// the clock enable.
// ---------------------------------------------------------------------------
module tb_scudsp_dma;

  localparam int AW  = 25;
  localparam int PAW = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ce;
  logic           st;
  logic           dir;
  logic [3:0]     ramw;
  logic           prgw;
  logic [3:0]     ramr;
  logic [7:0]     cnt;
  logic [2:0]     addi;
  logic           hold;
  logic [AW-1:0]  ra0_in;
  logic [AW-1:0]  wa0_in;
  logic [AW-1:0]  ra0_out;
  logic [AW-1:0]  wa0_out;
  logic           ra0_upd;
  logic           wa0_upd;
  logic [AW-1:0]  a_addr;
  logic [31:0]    a_do;
  logic [31:0]    a_di;
  logic           a_req;
  logic           a_we;
  logic           a_ack;
  logic [3:0]     ram_we;
  logic [3:0]     ram_re;
  logic [31:0]    ram_wd;
  logic [31:0]    ram_rd;
  logic [3:0]     ct_inc;
  logic           prg_we;
  logic [PAW-1:0] prg_addr;
  logic [31:0]    prg_wd;
  logic           busy;
  logic           done;

  scudsp_dma #(.AW(AW), .PAW(PAW)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .st(st), .dir(dir),
    .ramw(ramw), .prgw(prgw), .ramr(ramr), .cnt(cnt), .addi(addi),
    .hold(hold), .ra0_in(ra0_in), .wa0_in(wa0_in),
    .ra0_out(ra0_out), .wa0_out(wa0_out), .ra0_upd(ra0_upd), .wa0_upd(wa0_upd),
    .a_addr(a_addr), .a_do(a_do), .a_di(a_di), .a_req(a_req), .a_we(a_we),
    .a_ack(a_ack), .ram_we(ram_we), .ram_re(ram_re), .ram_wd(ram_wd),
    .ram_rd(ram_rd), .ct_inc(ct_inc), .prg_we(prg_we), .prg_addr(prg_addr),
    .prg_wd(prg_wd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  wire [197:0] allOuts = {ra0_out, wa0_out, ra0_upd, wa0_upd, a_addr, a_do,
                          a_req, a_we, ram_we, ram_re, ram_wd, ct_inc, prg_we,
                          prg_addr, prg_wd, busy, done};

  logic [63:0] expQ[$];
  logic [31:0] rdQ[$];
  logic [31:0] rrQ[$];
  int          checks = 0;
  int          passes = 0;
  int          ackDelay = 0;
  bit          ceToggle = 1'b0;
  int          busyClk = 0;
  int          busyCe = 0;

  // Event encodings, kind in the top nibble.
  function automatic logic [63:0] vStb(input logic [3:0] we, input logic [3:0] re,
                                       input logic [3:0] ct, input logic [31:0] wd);
    return {4'd1, 16'd0, we, re, ct, wd};
  endfunction

  function automatic logic [63:0] vPrg(input logic [7:0] a, input logic [31:0] d);
    return {4'd2, 20'd0, a, d};
  endfunction

  function automatic logic [63:0] vBus(input logic we, input logic [24:0] a,
                                       input logic [31:0] d);
    return {4'd3, 2'd0, we, a, d};
  endfunction

  function automatic logic [63:0] vFin(input logic r, input logic w,
                                       input logic [24:0] o);
    return {4'd4, 33'd0, r, w, o};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic scoreCheck(input logic [63:0] act);
    if (expQ.size() == 0) begin
      checks++;
      $display("[TB] FAIL unexpected_event: got %h, expected none", act);
    end else begin
      checkOutput("scoreboard", act, expQ.pop_front());
    end
  endtask

  // Monitor: pulses are sampled on the last cycle before an enabled edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ce && ((ram_we | ram_re | ct_inc) != 4'd0))
          scoreCheck(vStb(ram_we, ram_re, ct_inc, (ram_we != 4'd0) ? ram_wd : 32'd0));
        if (ce && prg_we)
          scoreCheck(vPrg(prg_addr, prg_wd));
        if (a_ack && a_req)
          scoreCheck(vBus(a_we, a_addr, a_we ? a_do : 32'd0));
        if (ce && done)
          scoreCheck(vFin(ra0_upd, wa0_upd,
                          ra0_upd ? ra0_out : (wa0_upd ? wa0_out : 25'd0)));
      end
    end
  end

  // Busy duration counters.
  initial begin
    forever begin
      @(negedge clk);
      if (busy) begin
        busyClk++;
        if (ce) busyCe++;
      end
    end
  end

  // Clock enable generator.
  initial begin
    ce = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ce = ceToggle ? ~ce : 1'b1;
    end
  end

  // D0 slave and data RAM read-data responder.
  initial begin
    int  waitCnt;
    bit  waitDrop;
    bit  reSeen;
    waitCnt = 0; waitDrop = 0; reSeen = 0;
    a_ack = 1'b0; a_di = '0; ram_rd = '0;
    forever begin
      @(posedge clk);
      #1;
      a_ack = 1'b0;
      if (!rst_n) begin
        waitCnt = 0; waitDrop = 0; reSeen = 0;
      end else begin
        if (a_req && !waitDrop) begin
          if (waitCnt >= ackDelay) begin
            a_ack = 1'b1;
            if (!a_we) a_di = (rdQ.size() != 0) ? rdQ.pop_front() : 32'hDEAD_BEEF;
            waitDrop = 1;
            waitCnt = 0;
          end else begin
            waitCnt++;
          end
        end else if (!a_req) begin
          waitDrop = 0;
        end
        if (ram_re != 4'd0 && !reSeen) begin
          ram_rd = (rrQ.size() != 0) ? rrQ.pop_front() : 32'hBAD0_BAD0;
          reSeen = 1;
        end else if (ram_re == 4'd0) begin
          reSeen = 0;
        end
      end
    end
  end

  // Present one start request and hold it across exactly one enabled edge.
  task automatic applyStimulus(input logic d, input logic [3:0] rw, input logic pw,
                               input logic [3:0] rr, input logic [7:0] c,
                               input logic [2:0] ai, input logic h,
                               input logic [24:0] ra, input logic [24:0] wa);
    @(negedge clk);
    dir = d; ramw = rw; prgw = pw; ramr = rr; cnt = c; addi = ai; hold = h;
    ra0_in = ra; wa0_in = wa; st = 1'b1;
    forever begin
      @(posedge clk);
      if (ce) break;
    end
    @(negedge clk);
    st = 1'b0;
  endtask

  task automatic waitIdle(input int maxCyc);
    int n = 0;
    while (busy) begin
      if (n >= maxCyc) begin
        checks++;
        $display("[TB] FAIL timeout: busy still %0d after %0d cycles, required 0", busy, n);
        break;
      end
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("drain", expQ.size(), 0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; st = 1'b0; dir = 1'b0; ramw = '0; prgw = 1'b0; ramr = '0;
    cnt = '0; addi = '0; hold = 1'b0; ra0_in = '0; wa0_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 64'(allOuts != '0), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // D0 -> RAM bank 0, four words, immediate acknowledge.
    $display("[TB] D0->RAM bank 0");
    for (int i = 0; i < 4; i++) begin
      rdQ.push_back(32'hA0 + i);
      expQ.push_back(vBus(1'b0, 25'h100 + i, 32'd0));
      expQ.push_back(vStb(4'b0001, 4'b0000, 4'b0001, 32'hA0 + i));
    end
    expQ.push_back(vFin(1'b1, 1'b0, 25'h104));
    busyClk = 0; busyCe = 0;
    applyStimulus(1'b0, 4'b0001, 1'b0, 4'b0000, 8'd4, 3'd1, 1'b0, 25'h100, 25'h0);
    waitIdle(100);
    checkOutput("t1_busy_cycles", busyClk, 9);

    // RAM bank 2 -> D0, two words, increment 4.
    $display("[TB] RAM->D0 bank 2");
    rrQ.push_back(32'h11); rrQ.push_back(32'h22);
    expQ.push_back(vStb(4'b0000, 4'b0100, 4'b0100, 32'd0));
    expQ.push_back(vBus(1'b1, 25'h200, 32'h11));
    expQ.push_back(vStb(4'b0000, 4'b0100, 4'b0100, 32'd0));
    expQ.push_back(vBus(1'b1, 25'h204, 32'h22));
    expQ.push_back(vFin(1'b0, 1'b1, 25'h208));
    busyClk = 0; busyCe = 0;
    applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0100, 8'd2, 3'd3, 1'b0, 25'h0, 25'h200);
    waitIdle(100);
    checkOutput("t2_busy_cycles", busyClk, 7);

    // Program load of 256 words with hold set.
    $display("[TB] program load");
    for (int i = 0; i < 256; i++) begin
      rdQ.push_back(32'hC000_0000 + i);
      expQ.push_back(vBus(1'b0, 25'h1000 + i, 32'd0));
      expQ.push_back(vPrg(8'(i), 32'hC000_0000 + i));
    end
    expQ.push_back(vFin(1'b0, 1'b0, 25'd0));
    busyClk = 0; busyCe = 0;
    applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 8'd0, 3'd1, 1'b1, 25'h1000, 25'h0);
    waitIdle(1000);
    checkOutput("t3_busy_cycles", busyClk, 513);

    // Delayed acknowledge and address wrap.
    $display("[TB] wait states and wrap");
    ackDelay = 5;
    rdQ.push_back(32'h5555); rdQ.push_back(32'h6666);
    expQ.push_back(vBus(1'b0, 25'h1FF_FFFF, 32'd0));
    expQ.push_back(vStb(4'b1000, 4'b0000, 4'b1000, 32'h5555));
    expQ.push_back(vBus(1'b0, 25'h000_0000, 32'd0));
    expQ.push_back(vStb(4'b1000, 4'b0000, 4'b1000, 32'h6666));
    expQ.push_back(vFin(1'b1, 1'b0, 25'h000_0001));
    busyClk = 0; busyCe = 0;
    applyStimulus(1'b0, 4'b1000, 1'b0, 4'b0000, 8'd2, 3'd1, 1'b0, 25'h1FF_FFFF, 25'h0);
    waitIdle(200);
    checkOutput("t4_busy_cycles", busyClk, 15);
    ackDelay = 0;

    // Abort during word 2 of a 4-word transfer.
    $display("[TB] abort");
    for (int i = 0; i < 4; i++) rdQ.push_back(32'hB0 + i);
    expQ.push_back(vBus(1'b0, 25'h400, 32'd0));
    expQ.push_back(vStb(4'b0001, 4'b0000, 4'b0001, 32'hB0));
    applyStimulus(1'b0, 4'b0001, 1'b0, 4'b0000, 8'd4, 3'd1, 1'b0, 25'h400, 25'h0);
    begin
      int n = 0;
      while (ram_we == 4'd0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) begin
        checks++;
        $display("[TB] FAIL abort_wait: ram_we %b after %0d cycles, required nonzero", ram_we, n);
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("abort_outputs", 64'(allOuts != '0), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdQ.delete();
    repeat (3) @(negedge clk);
    checkOutput("abort_idle", busy, 0);
    checkOutput("abort_drain", expQ.size(), 0);

    // Fresh run after abort, fixed address (mode 0).
    $display("[TB] fresh run after abort");
    rdQ.push_back(32'hD0); rdQ.push_back(32'hD1);
    expQ.push_back(vBus(1'b0, 25'h40, 32'd0));
    expQ.push_back(vStb(4'b0001, 4'b0000, 4'b0001, 32'hD0));
    expQ.push_back(vBus(1'b0, 25'h40, 32'd0));
    expQ.push_back(vStb(4'b0001, 4'b0000, 4'b0001, 32'hD1));
    expQ.push_back(vFin(1'b1, 1'b0, 25'h40));
    applyStimulus(1'b0, 4'b0001, 1'b0, 4'b0000, 8'd2, 3'd0, 1'b0, 25'h40, 25'h0);
    waitIdle(100);

    // Toggling clock enable with a second start while busy.
    $display("[TB] ce toggling and ignored start");
    ceToggle = 1'b1;
    rdQ.push_back(32'hE0); rdQ.push_back(32'hE1);
    expQ.push_back(vBus(1'b0, 25'h300, 32'd0));
    expQ.push_back(vStb(4'b0010, 4'b0000, 4'b0010, 32'hE0));
    expQ.push_back(vBus(1'b0, 25'h302, 32'd0));
    expQ.push_back(vStb(4'b0010, 4'b0000, 4'b0010, 32'hE1));
    expQ.push_back(vFin(1'b1, 1'b0, 25'h304));
    busyClk = 0; busyCe = 0;
    applyStimulus(1'b0, 4'b0010, 1'b0, 4'b0000, 8'd2, 3'd2, 1'b0, 25'h300, 25'h0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0001, 8'd5, 3'd1, 1'b0, 25'h0, 25'h777);
    waitIdle(100);
    checkOutput("t6_busy_ce_cycles", busyCe, 5);
    checkOutput("t6_busy_clk_cycles", busyClk, 10);
    checkOutput("t6_req_idle", a_req, 0);
    ceToggle = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
